game_ctrl: RTL and testbench

- Top-level sequencer for the jumping-runner game.
- Generates the frame tick that paces the role and obstacle movers, and drives their Stop input.
- Turns the jump button into a one-cycle jump request.
- Detects role/obstacle collision and runs the IDLE/PLAY/HIT/OVER game state machine.
- Keeps a BCD score, a high score and a speed level for the obstacle scroller.

---
 rtl/game_pkg.sv | 26 ++
 rtl/bcd_counter4.sv | 44 ++++
 rtl/game_ctrl.sv | 141 ++++++++++++++
 tb/tb_game_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the jumping-runner game: state encodings, screen
// constants and default sprite sizes used by the sequencer and the movers.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_HIT  = 2'd2,
    ST_OVER = 2'd3
  } game_state_t;

  localparam int unsigned GROUND_Y   = 400;
  localparam int unsigned SCREEN_W   = 640;
  localparam int unsigned ROLE_W_DEF = 40;
  localparam int unsigned ROLE_H_DEF = 43;
  localparam int unsigned OBS_W_DEF  = 20;
  localparam int unsigned OBS_H_DEF  = 40;

  localparam logic [2:0] SPEED_MAX = 3'd7;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD counter that saturates at 9999; flags the increment that
// carries into the hundreds digit.
module bcd_counter4 (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] q,
  output logic        hund_carry
);

  logic [15:0] q_inc;
  logic        carry;
  logic        sat;

  assign sat        = (q == 16'h9999);
  assign hund_carry = inc && !clr && !sat && (q[7:0] == 8'h99);

  always_comb begin
    q_inc = q;
    carry = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (carry) begin
        if (q[i*4 +: 4] == 4'd9) begin
          q_inc[i*4 +: 4] = 4'd0;
        end else begin
          q_inc[i*4 +: 4] = q[i*4 +: 4] + 4'd1;
          carry           = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && !sat) begin
      q <= q_inc;
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// Game sequencer: frame pacing, button edges, collision test, IDLE/PLAY/HIT/OVER
// state machine, BCD score, high score and speed level.
module game_ctrl
  import game_pkg::*;
#(
  parameter int unsigned CLK_PER_FRAME = 833333,
  parameter int unsigned ROLE_W        = ROLE_W_DEF,
  parameter int unsigned ROLE_H        = ROLE_H_DEF,
  parameter int unsigned OBS_W         = OBS_W_DEF,
  parameter int unsigned OBS_H         = OBS_H_DEF,
  parameter int unsigned SCORE_DIV     = 6,
  parameter int unsigned HIT_HOLD      = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Start_Button,
  input  logic        Jump_Button,
  input  logic [9:0]  Role_X,
  input  logic [9:0]  Role_Y,
  input  logic [9:0]  Obs_X,
  input  logic [9:0]  Obs_Y,
  input  logic        Obs_Valid,
  output logic        Frame_Tick,
  output logic        Stop,
  output logic        Jump_Pulse,
  output logic [1:0]  State,
  output logic [15:0] Score,
  output logic [15:0] High_Score,
  output logic [2:0]  Speed
);

  localparam int unsigned FRAME_W = cnt_w(CLK_PER_FRAME);
  localparam int unsigned DIV_W   = cnt_w(SCORE_DIV);
  localparam int unsigned HOLD_W  = cnt_w(HIT_HOLD);

  game_state_t       state, state_nxt;
  logic [FRAME_W-1:0] frame_cnt;
  logic [DIV_W-1:0]   div_cnt, div_nxt;
  logic [HOLD_W-1:0]  hold_cnt, hold_nxt;
  logic               start_q, jump_q;
  logic               start_rise, jump_rise;
  logic               overlap;
  logic               game_start, score_clr, score_inc, hi_load;
  logic               hund_carry;

  assign Frame_Tick = (frame_cnt == FRAME_W'(CLK_PER_FRAME - 1));
  assign start_rise = Start_Button && !start_q;
  assign jump_rise  = Jump_Button && !jump_q;
  assign Stop       = (state != ST_PLAY);
  assign State      = state;

  // Zero-extended to 11 bits so right/bottom edges near 1023 cannot wrap.
  assign overlap = Obs_Valid
                && ({1'b0, Role_X} < {1'b0, Obs_X} + 11'(OBS_W))
                && ({1'b0, Obs_X}  < {1'b0, Role_X} + 11'(ROLE_W))
                && ({1'b0, Role_Y} < {1'b0, Obs_Y} + 11'(OBS_H))
                && ({1'b0, Obs_Y}  < {1'b0, Role_Y} + 11'(ROLE_H));

  always_comb begin
    state_nxt  = state;
    div_nxt    = div_cnt;
    hold_nxt   = hold_cnt;
    game_start = 1'b0;
    score_inc  = 1'b0;
    hi_load    = 1'b0;
    case (state)
      ST_IDLE: game_start = start_rise || jump_rise;
      ST_PLAY: begin
        if (Frame_Tick) begin
          if (overlap) begin
            state_nxt = ST_HIT;
            hold_nxt  = '0;
          end else if (div_cnt == DIV_W'(SCORE_DIV - 1)) begin
            div_nxt   = '0;
            score_inc = 1'b1;
          end else begin
            div_nxt = div_cnt + DIV_W'(1);
          end
        end
      end
      ST_HIT: begin
        if (Frame_Tick) begin
          if (hold_cnt == HOLD_W'(HIT_HOLD - 1)) begin
            state_nxt = ST_OVER;
            hi_load   = (Score > High_Score);
          end else begin
            hold_nxt = hold_cnt + HOLD_W'(1);
          end
        end
      end
      ST_OVER: game_start = start_rise;
      default: state_nxt = ST_IDLE;
    endcase
    if (game_start) begin
      state_nxt = ST_PLAY;
      div_nxt   = '0;
    end
  end

  assign score_clr = game_start;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      frame_cnt  <= '0;
      div_cnt    <= '0;
      hold_cnt   <= '0;
      start_q    <= 1'b0;
      jump_q     <= 1'b0;
      Jump_Pulse <= 1'b0;
      High_Score <= '0;
      Speed      <= '0;
    end else begin
      state      <= state_nxt;
      frame_cnt  <= Frame_Tick ? '0 : frame_cnt + FRAME_W'(1);
      div_cnt    <= div_nxt;
      hold_cnt   <= hold_nxt;
      start_q    <= Start_Button;
      jump_q     <= Jump_Button;
      Jump_Pulse <= jump_rise && (state == ST_PLAY);
      if (hi_load) begin
        High_Score <= Score;
      end
      if (game_start) begin
        Speed <= '0;
      end else if (hund_carry && Speed != SPEED_MAX) begin
        Speed <= Speed + 3'd1;
      end
    end
  end

  bcd_counter4 u_score (
    .clk        (clk),
    .rst        (rst),
    .clr        (score_clr),
    .inc        (score_inc),
    .q          (Score),
    .hund_carry (hund_carry)
  );

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: idle pacing, jump edges, scoring, collision,
// hit hold, high score, async reset and score saturation (fast second instance).
module tb_game_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_btn = 1'b0, jump_btn = 1'b0;
  logic [9:0]  role_x = 10'd10, role_y = 10'd357, obs_x = 10'd50, obs_y = 10'd360;
  logic        obs_valid = 1'b0;
  logic        frame_tick, stop, jump_pulse;
  logic [1:0]  state;
  logic [15:0] score, high_score;
  logic [2:0]  speed;

  logic        start2 = 1'b0;
  logic        frame_tick2, stop2, jump_pulse2;
  logic [1:0]  state2;
  logic [15:0] score2, high_score2;
  logic [2:0]  speed2;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned play_ticks = 0;

  always #5 clk = ~clk;

  game_ctrl #(.CLK_PER_FRAME(4), .SCORE_DIV(2), .HIT_HOLD(3)) dut (
    .clk(clk), .rst(rst), .Start_Button(start_btn), .Jump_Button(jump_btn),
    .Role_X(role_x), .Role_Y(role_y), .Obs_X(obs_x), .Obs_Y(obs_y),
    .Obs_Valid(obs_valid), .Frame_Tick(frame_tick), .Stop(stop),
    .Jump_Pulse(jump_pulse), .State(state), .Score(score),
    .High_Score(high_score), .Speed(speed)
  );

  game_ctrl #(.CLK_PER_FRAME(2), .SCORE_DIV(1), .HIT_HOLD(3)) dut_fast (
    .clk(clk), .rst(rst), .Start_Button(start2), .Jump_Button(1'b0),
    .Role_X(10'd0), .Role_Y(10'd0), .Obs_X(10'd0), .Obs_Y(10'd0),
    .Obs_Valid(1'b0), .Frame_Tick(frame_tick2), .Stop(stop2),
    .Jump_Pulse(jump_pulse2), .State(state2), .Score(score2),
    .High_Score(high_score2), .Speed(speed2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (frame_tick && state == 2'd1) play_ticks++;
  endtask

  // Advance past the next frame tick; returns on the negedge after its clock edge.
  task automatic next_frame();
    int unsigned n = 0;
    while (!frame_tick && n < 20) begin
      step();
      n++;
    end
    chk("frame_seen", {31'd0, frame_tick}, 32'd1);
    step();
  endtask

  task automatic wait_score(input logic [15:0] target, input int unsigned bound);
    int unsigned n = 0;
    while (score != target && n < bound) begin
      step();
      n++;
    end
    chk("score_reach", {16'd0, score}, {16'd0, target});
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, {30'd0, state}, 32'd0);
    chk({tag, "_stop"},  {31'd0, stop}, 32'd1);
    chk({tag, "_tick"},  {31'd0, frame_tick}, 32'd0);
    chk({tag, "_jump"},  {31'd0, jump_pulse}, 32'd0);
    chk({tag, "_score"}, {16'd0, score}, 32'd0);
    chk({tag, "_high"},  {16'd0, high_score}, 32'd0);
    chk({tag, "_speed"}, {29'd0, speed}, 32'd0);
  endtask

  initial begin
    int unsigned ticks, first_tick, pulses, n;

    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rst = 1'b1;

    // Idle pacing: ticks at steps 3,7,11,15,19 after release
    ticks = 0;
    first_tick = 0;
    for (int unsigned k = 1; k <= 20; k++) begin
      step();
      if (frame_tick) begin
        if (ticks == 0) first_tick = k;
        ticks++;
      end
      if (state != 2'd0 || !stop || score != 16'h0) chk("idle_hold", {30'd0, state}, 32'd0);
    end
    chk("idle_ticks", ticks, 32'd5);
    chk("idle_first_tick", first_tick, 32'd3);
    chk("idle_state", {30'd0, state}, 32'd0);

    // Game 1: jump starts, then jump edges in PLAY
    jump_btn = 1'b1;
    step();
    chk("start_state", {30'd0, state}, 32'd1);
    chk("start_stop", {31'd0, stop}, 32'd0);
    chk("start_nojump", {31'd0, jump_pulse}, 32'd0);
    jump_btn = 1'b0;
    step();
    step();
    jump_btn = 1'b1;
    step();
    chk("jump_pulse", {31'd0, jump_pulse}, 32'd1);
    pulses = 0;
    for (int unsigned k = 0; k < 10; k++) begin
      step();
      if (jump_pulse) pulses++;
    end
    chk("jump_hold", pulses, 32'd0);
    jump_btn = 1'b0;

    wait_score(16'h0010, 400);
    obs_valid = 1'b1;
    obs_x = 10'd50;
    wait_score(16'h0012, 100);
    chk("touch_nohit", {30'd0, state}, 32'd1);
    obs_x = 10'd49;
    next_frame();
    chk("hit_state", {30'd0, state}, 32'd2);
    chk("hit_stop", {31'd0, stop}, 32'd1);
    chk("hit_score", {16'd0, score}, 32'h0012);
    next_frame();
    chk("hold1", {30'd0, state}, 32'd2);
    next_frame();
    chk("hold2", {30'd0, state}, 32'd2);
    next_frame();
    chk("over_state", {30'd0, state}, 32'd3);
    chk("over_high", {16'd0, high_score}, 32'h0012);

    jump_btn = 1'b1;
    step();
    step();
    chk("over_jump_ign", {30'd0, state}, 32'd3);
    jump_btn = 1'b0;
    step();

    // Game 2: lower score leaves high score alone
    obs_valid = 1'b0;
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    chk("restart_state", {30'd0, state}, 32'd1);
    chk("restart_score", {16'd0, score}, 32'd0);
    wait_score(16'h0005, 200);
    obs_valid = 1'b1;
    next_frame();
    chk("hit2_state", {30'd0, state}, 32'd2);
    repeat (3) next_frame();
    chk("over2_state", {30'd0, state}, 32'd3);
    chk("over2_high", {16'd0, high_score}, 32'h0012);
    chk("over2_score", {16'd0, score}, 32'h0005);

    // Game 3: 200 frames -> 0x0100 and speed 1
    obs_valid = 1'b0;
    play_ticks = 0;
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    chk("g3_score0", {16'd0, score}, 32'd0);
    chk("g3_speed0", {29'd0, speed}, 32'd0);
    wait_score(16'h0100, 2000);
    chk("g3_frames", play_ticks, 32'd200);
    chk("g3_speed", {29'd0, speed}, 32'd1);

    // Async reset mid-frame while playing
    step();
    step();
    #3 rst = 1'b0;
    #1 chk_reset_vals("midrst");
    @(negedge clk);
    rst = 1'b1;

    // Saturation on the fast instance
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    n = 0;
    while (score2 != 16'h9999 && n < 21000) begin
      @(negedge clk);
      n++;
    end
    repeat (20) @(negedge clk);
    chk("sat_score", {16'd0, score2}, 32'h9999);
    chk("sat_speed", {29'd0, speed2}, 32'd7);
    chk("sat_state", {30'd0, state2}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
